// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned IFU_DATA_WIDTH = 32;
    localparam int unsigned IFU_ADDR_WIDTH = 32;
    localparam int unsigned IFU_MEM_DEPTH  = 256;

    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_LOAD,
        S_FETCH,
        S_VALID,
        S_HALT
    } ifu_state_e;

    function automatic logic is_word_aligned(input logic [1:0] byte_offset);
        return byte_offset == 2'b00;
    endfunction

endpackage

// File: rtl/imem_sram.sv
// 1R1W synchronous word array with a registered read port; contents are never reset.
module imem_sram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned IDX_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: program loader, single-word fetch FSM and valid/ready output.
// Optional macro IFU_FETCH_COUNT_EN adds a saturating fetch_count of pc_advance pulses.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IFU_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = IFU_ADDR_WIDTH,
    parameter int unsigned MEM_DEPTH  = IFU_MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  load_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic                  pc_advance,
    output logic                  halted,
    output logic                  fetch_err
`ifdef IFU_FETCH_COUNT_EN
    ,
    output logic [31:0]           fetch_count
`endif
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] DEPTH_IDX = (ADDR_WIDTH-2)'(MEM_DEPTH);

    ifu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  fetch_err_q, fetch_err_d;
    // Selects the array read data once a fetch has happened; NOP until then.
    logic                  rdata_sel_q, rdata_sel_d;

    logic [ADDR_WIDTH-3:0] pc_idx, wr_idx;
    logic                  pc_in_range, wr_in_range;
    logic                  mem_we, mem_re;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [1:0]            unused_wr_lsb;

    assign pc_idx        = pc[ADDR_WIDTH-1:2];
    assign wr_idx        = wr_addr[ADDR_WIDTH-1:2];
    assign pc_in_range   = pc_idx < DEPTH_IDX;
    assign wr_in_range   = wr_idx < DEPTH_IDX;
    assign unused_wr_lsb = wr_addr[1:0];

    imem_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_imem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wr_idx[IDX_W-1:0]),
        .wdata_i (wr_data),
        .re_i    (mem_re),
        .raddr_i (pc_idx[IDX_W-1:0]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d       = state_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        rdata_sel_d   = rdata_sel_q;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        pc_advance    = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                mem_we = wr_en && wr_in_range;
                if (start && !load_en) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!is_word_aligned(pc[1:0]) || !pc_in_range) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    mem_re        = 1'b1;
                    instr_pc_d    = pc;
                    instr_valid_d = 1'b1;
                    rdata_sel_d   = 1'b1;
                    state_d       = S_VALID;
                end
            end
            S_VALID: begin
                if (instr_ready) begin
                    pc_advance    = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = (instr_out == DATA_WIDTH'(INSTR_EBREAK)) ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (load_en) begin
                    fetch_err_d = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= S_LOAD;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            rdata_sel_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            rdata_sel_q   <= rdata_sel_d;
        end
    end

    assign instr_out   = rdata_sel_q ? mem_rdata : DATA_WIDTH'(INSTR_NOP);
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = state_q == S_HALT;
    assign fetch_err   = fetch_err_q;

`ifdef IFU_FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (state_d == S_LOAD && state_q != S_LOAD) begin
            fetch_count_d = '0;
        end else if (pc_advance && fetch_count_q != 32'hFFFF_FFFF) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule
